// File: rtl/run_pattern_generator.sv
// -----------------------------------------------------------------------------
// run_pattern_generator
//
// Serial stimulus transmitter for the run-of-four sequence detector. A parallel
// pattern (bit 0 first) and a length are accepted in IDLE and shifted out on w,
// one bit per Clock. Alongside the serial stream the block produces z_exp, the
// golden "four or more equal consecutive bits" flag, timed to match the
// detector's state-based z output so the two can be compared directly.
//
// Optional feature macro: PATTERN_REPEAT_EN
//   When defined, a repeat_i input is added. If repeat_i is high in the cycle
//   the last bit of a pass is emitted, the pattern is reloaded from a shadow
//   copy and shifting continues with no gap and no done pulse. The input is
//   named repeat_i because "repeat" is a reserved word.
//
// Parameters
//   WIDTH  pattern register width in bits (>= 4)
//   CNT_W  width of the length field and bit counter; must be able to hold WIDTH
//
// Ports
//   Clock     in   1      single clock, rising edge
//   Reset     in   1      asynchronous, active-low
//   in_valid  in   1      a pattern is offered
//   in_ready  out  1      generator can accept a pattern (IDLE, out of reset)
//   in_pat    in   WIDTH  pattern to transmit, bit 0 sent first
//   in_len    in   CNT_W  number of bits to send (clamped to WIDTH)
//   repeat_i  in   1      [PATTERN_REPEAT_EN] reload pattern after last bit
//   w         out  1      serial data; holds the last emitted bit when idle
//   w_valid   out  1      w carries a pattern bit this cycle
//   z_exp     out  1      expected detector output
//   busy      out  1      state != IDLE
//   done      out  1      one-cycle pulse in the cycle after the last bit
// -----------------------------------------------------------------------------
module run_pattern_generator #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pat,
  input  logic [CNT_W-1:0] in_len,
`ifdef PATTERN_REPEAT_EN
  input  logic             repeat_i,
`endif
  output logic             w,
  output logic             w_valid,
  output logic             z_exp,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [2:0]       RUN_MAX = 3'd4;

  // Lengths beyond the pattern register are clamped to the register width.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
    if (len > WIDTH_C) begin
      return WIDTH_C;
    end
    return len;
  endfunction

  // Run length update: saturate at four on a repeated bit, restart at one on a
  // change. Saturation keeps the counter small; only "reached four" matters.
  function automatic logic [2:0] run_step(input logic [2:0] run, input logic same);
    if (!same) begin
      return 3'd1;
    end
    if (run >= RUN_MAX) begin
      return RUN_MAX;
    end
    return run + 3'd1;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       run_q, run_d;
  logic             last_q, last_d;
  logic             z_q, z_d;
  logic             take;
  logic             emit;

`ifdef PATTERN_REPEAT_EN
  logic [WIDTH-1:0] shd_pat_q, shd_pat_d;
  logic [CNT_W-1:0] shd_len_q, shd_len_d;
`endif

  // in_ready is also gated by Reset so it reads 0 throughout reset.
  assign in_ready = (state_q == ST_IDLE) && Reset;
  assign take     = in_valid && in_ready;
  assign emit     = (state_q == ST_SHIFT);

  // When not shifting, w repeats the last emitted bit so it never toggles
  // between patterns; last_q is the run tracker's copy of that bit.
  assign w        = emit ? sr_q[0] : last_q;
  assign w_valid  = emit;
  assign z_exp    = z_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    rem_d   = rem_q;
`ifdef PATTERN_REPEAT_EN
    shd_pat_d = shd_pat_q;
    shd_len_d = shd_len_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          sr_d  = in_pat;
          rem_d = clamp_len(in_len);
`ifdef PATTERN_REPEAT_EN
          shd_pat_d = in_pat;
          shd_len_d = clamp_len(in_len);
`endif
          // A zero-length request skips straight to the done pulse.
          state_d = (in_len == '0) ? ST_DONE : ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        sr_d  = sr_q >> 1;
        rem_d = rem_q - ONE_C;
        // "<=" rather than "==" so a corrupted zero count still terminates.
        if (rem_q <= ONE_C) begin
          state_d = ST_DONE;
`ifdef PATTERN_REPEAT_EN
          if (repeat_i) begin
            state_d = ST_SHIFT;
            sr_d    = shd_pat_q;
            rem_d   = shd_len_q;
          end
`endif
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Run tracker: follows the continuous stream across patterns, updated only
  // on bit cycles. z is registered from the updated run so it rises the cycle
  // after the fourth equal bit, like the detector's Moore output.
  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    if (emit) begin
      run_d  = run_step(run_q, sr_q[0] == last_q);
      last_d = sr_q[0];
    end
    z_d = (run_d == RUN_MAX);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      rem_q   <= '0;
      run_q   <= '0;
      last_q  <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      run_q   <= run_d;
      last_q  <= last_d;
      z_q     <= z_d;
    end
  end

`ifdef PATTERN_REPEAT_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      shd_pat_q <= '0;
      shd_len_q <= '0;
    end else begin
      shd_pat_q <= shd_pat_d;
      shd_len_q <= shd_len_d;
    end
  end
`endif

endmodule

// File: tb/tb_run_pattern_generator.sv
module tb_run_pattern_generator;
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_pat = '0;
  logic [CNT_W-1:0] in_len = '0;
`ifdef PATTERN_REPEAT_EN
  logic             rpt = 1'b0;
`endif
  logic             w, w_valid, z_exp, busy, done;

  run_pattern_generator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pat   (in_pat),
    .in_len   (in_len),
`ifdef PATTERN_REPEAT_EN
    .repeat_i (rpt),
`endif
    .w        (w),
    .w_valid  (w_valid),
    .z_exp    (z_exp),
    .busy     (busy),
    .done     (done)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model is a schedule of what the outputs must show, one entry per
  // future cycle: pattern bits, then one done entry. Empty schedule = idle.
  typedef struct {
    bit is_done;
    bit b;
    bit last;
  } ent_t;

  ent_t             q[$];
  bit               m_last = 1'b0;
  int               m_run  = 0;
  bit               m_z    = 1'b0;
  logic [WIDTH-1:0] m_pat  = '0;
  int               m_len  = 0;

  ent_t e;
  bit   hs, ev, ed, eb;

  task automatic push_pass();
    for (int i = 0; i < m_len; i++) begin
      q.push_back('{is_done: 1'b0, b: m_pat[i], last: (i == m_len - 1)});
    end
    q.push_back('{is_done: 1'b1, b: 1'b0, last: 1'b0});
  endtask

  always @(negedge Clock) begin
    if (!Reset) begin
      chk("rst_w", w, 0);
      chk("rst_w_valid", w_valid, 0);
      chk("rst_z_exp", z_exp, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);
      q.delete();
      m_last = 1'b0;
      m_run  = 0;
      m_z    = 1'b0;
    end else begin
      ev = (q.size() > 0) && !q[0].is_done;
      ed = (q.size() > 0) && q[0].is_done;
      eb = ev ? q[0].b : m_last;
      chk("w", w, eb);
      chk("w_valid", w_valid, ev);
      chk("z_exp", z_exp, m_z);
      chk("busy", busy, q.size() > 0);
      chk("done", done, ed);
      chk("in_ready", in_ready, q.size() == 0);
      hs = in_valid && (q.size() == 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.is_done) begin
          if (e.b == m_last) m_run = (m_run < 4) ? m_run + 1 : 4;
          else m_run = 1;
          m_last = e.b;
`ifdef PATTERN_REPEAT_EN
          if (e.last && rpt) begin
            void'(q.pop_front());
            push_pass();
          end
`endif
        end
      end
      m_z = (m_run == 4);
      if (hs) begin
        m_pat = in_pat;
        m_len = (int'(in_len) > WIDTH) ? WIDTH : int'(in_len);
        push_pass();
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_timeout", in_ready, 1);
  endtask

  task automatic send(input logic [WIDTH-1:0] p, input int l);
    wait_ready();
    in_pat   = p;
    in_len   = CNT_W'(l);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_pat   = WIDTH'($urandom);
    in_len   = CNT_W'($urandom);
  endtask

  bit exp_w[9]    = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
  bit exp_v[9]    = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
  bit exp_z[9]    = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
  bit exp_done[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    int n;
    int cyc;
    // Reset and idle
    repeat (3) tick();
    Reset = 1'b1;
    repeat (3) tick();
    chk("idle_in_ready", in_ready, 1);
    chk("idle_w", w, 0);
    chk("idle_busy", busy, 0);

    // 0x000F, len 8
    send(16'h000F, 8);
    for (int k = 0; k < 9; k++) begin
      chk("t2_w", w, exp_w[k]);
      chk("t2_w_valid", w_valid, exp_v[k]);
      chk("t2_z_exp", z_exp, exp_z[k]);
      chk("t2_done", done, exp_done[k]);
      tick();
    end

    // Run spans two patterns
    send(16'h0003, 4);
    chk("t3_z_carry", z_exp, 1);
    repeat (4) tick();
    send(16'h0000, 2);
    tick();
    chk("t3_z_bit2", z_exp, 0);
    tick();
    chk("t3_z_after", z_exp, 1);
    chk("t3_done", done, 1);

    // Zero length and clamped length
    send(16'hFFFF, 0);
    chk("t4_zero_done", done, 1);
    chk("t4_zero_valid", w_valid, 0);
    tick();
    chk("t4_zero_done_end", done, 0);
    chk("t4_zero_ready", in_ready, 1);
    send(16'hA5A5, 20);
    n = 0;
    cyc = 0;
    while (!done && cyc < 40) begin
      if (w_valid) n++;
      tick();
      cyc++;
    end
    chk("t4_clamp_bits", n, 16);

    // Reset mid-pattern
    send(16'h00F0, 8);
    repeat (2) tick();
    Reset = 1'b0;
    #1;
    chk("t5_valid", w_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    tick();
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t5_no_done", done, 0);
      tick();
    end
    send(16'h1234, 16);
    repeat (17) tick();

`ifdef PATTERN_REPEAT_EN
    // Repeat for three passes
    begin
      int vcnt, dcnt, zcnt;
      vcnt = 0;
      dcnt = 0;
      zcnt = 0;
      rpt = 1'b1;
      send(16'h0005, 4);
      for (int k = 0; k < 14; k++) begin
        if (k == 8) rpt = 1'b0;
        if (k < 12) chk("t6_contig", w_valid, 1);
        if (w_valid) vcnt++;
        if (done) dcnt++;
        if (k >= 1 && z_exp) zcnt++;
        tick();
      end
      chk("t6_bits", vcnt, 12);
      chk("t6_done_cnt", dcnt, 1);
      chk("t6_no_z", zcnt, 0);
    end
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 200; it++) begin
      send(WIDTH'($urandom), int'($urandom_range(0, 20)));
`ifdef PATTERN_REPEAT_EN
      rpt = ($urandom_range(0, 3) == 0);
`endif
      repeat ($urandom_range(0, 6)) tick();
      if ($urandom_range(0, 19) == 0) begin
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
      end
`ifdef PATTERN_REPEAT_EN
      rpt = 1'b0;
`endif
    end
    repeat (25) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
